// File: rtl/prci_reset_seq_pkg.sv
// ---------------------------------------------------------------------------
// prci_reset_seq_pkg
// Shared definitions for the PRCI reset sequencer. The APB status decode
// imports this package to interpret o_state.
//   state_e             : sequencer state type, 3-bit encoding
//   *_DEF               : default timing constants in i_clk cycles
//   st_*_up()           : which resets are released in a given state
// ---------------------------------------------------------------------------
package prci_reset_seq_pkg;

   typedef enum logic [2:0] {
      ST_IDLE       = 3'd0,
      ST_WAIT_LOCK  = 3'd1,
      ST_DBG_REL    = 3'd2,
      ST_DDR_REL    = 3'd3,
      ST_WAIT_CALIB = 3'd4,
      ST_RUN        = 3'd5,
      ST_DM_RST     = 3'd6
   } state_e;

   localparam logic [15:0] LOCK_WAIT_DEF     = 16'd64;
   localparam logic [15:0] DDR_DELAY_DEF     = 16'd16;
   localparam logic [15:0] CALIB_TIMEOUT_DEF = 16'hFFFF;
   localparam logic [15:0] DMI_HOLD_DEF      = 16'd8;

   // Debug domain is out of reset from DBG_REL onwards, including DM_RST.
   function automatic logic st_dbg_up(input state_e s);
      return (s == ST_DBG_REL) || (s == ST_DDR_REL) || (s == ST_WAIT_CALIB) ||
             (s == ST_RUN) || (s == ST_DM_RST);
   endfunction

   // DDR controller is out of reset from DDR_REL onwards, including DM_RST.
   function automatic logic st_ddr_up(input state_e s);
      return (s == ST_DDR_REL) || (s == ST_WAIT_CALIB) ||
             (s == ST_RUN) || (s == ST_DM_RST);
   endfunction

   // System domain runs only in RUN; DM_RST pulls it back down.
   function automatic logic st_sys_up(input state_e s);
      return (s == ST_RUN);
   endfunction

endpackage

// File: rtl/prci_reset_seq_sync.sv
// ---------------------------------------------------------------------------
// prci_reset_seq_sync
// Generic 2-flop synchroniser with asynchronous active-low reset.
//   i_clk  : destination clock
//   i_nrst : asynchronous active-low reset, clears both flops
//   i_d    : asynchronous input level
//   o_q    : synchronised level, 2 cycles of latency
// ---------------------------------------------------------------------------
module prci_reset_seq_sync (
   input  logic i_clk,
   input  logic i_nrst,
   input  logic i_d,
   output logic o_q
);

   logic meta_q;
   logic sync_q;

   always_ff @(posedge i_clk or negedge i_nrst) begin
      if (!i_nrst) begin
         meta_q <= 1'b0;
         sync_q <= 1'b0;
      end else begin
         meta_q <= i_d;
         sync_q <= meta_q;
      end
   end

   assign o_q = sync_q;

endmodule

// File: rtl/prci_reset_seq.sv
// ---------------------------------------------------------------------------
// prci_reset_seq
// Reset sequencer: releases debug, DDR and system resets in order once the
// PLL has been stably locked, waits for DDR calibration (with timeout) and
// handles debug-module reset requests and loss of lock.
//   i_clk            : reference clock (always running)
//   i_nrst           : power-on reset, asynchronous, active-low
//   i_pll_lock       : PLL locked (asynchronous, synchronised here)
//   i_dmireset       : debug-module reset request level (asynchronous)
//   i_ddr_calib_done : DDR calibration complete (DDR UI domain)
//   o_dbg_nrst       : debug-domain reset, active-low
//   o_ddr_nrst       : DDR controller reset, active-low
//   o_sys_nrst       : system reset, active-low
//   o_state          : current state encoding (state_e)
//   o_calib_timeout  : sticky, system released without calibration
// ---------------------------------------------------------------------------
module prci_reset_seq
   import prci_reset_seq_pkg::*;
#(
   parameter logic [15:0] LOCK_WAIT     = LOCK_WAIT_DEF,
   parameter logic [15:0] DDR_DELAY     = DDR_DELAY_DEF,
   parameter logic [15:0] CALIB_TIMEOUT = CALIB_TIMEOUT_DEF,
   parameter logic [15:0] DMI_HOLD      = DMI_HOLD_DEF
) (
   input  logic       i_clk,
   input  logic       i_nrst,
   input  logic       i_pll_lock,
   input  logic       i_dmireset,
   input  logic       i_ddr_calib_done,
   output logic       o_dbg_nrst,
   output logic       o_ddr_nrst,
   output logic       o_sys_nrst,
   output logic [2:0] o_state,
   output logic       o_calib_timeout
);

   // Bit 0: lock, bit 1: dmi request, bit 2: calibration done.
   logic [2:0] async_in;
   logic [2:0] sync_out;
   logic       lock_s;
   logic       dmi_s;
   logic       calib_s;

   assign async_in = {i_ddr_calib_done, i_dmireset, i_pll_lock};

   for (genvar gi = 0; gi < 3; gi++) begin : g_sync
      prci_reset_seq_sync u_sync (
         .i_clk  (i_clk),
         .i_nrst (i_nrst),
         .i_d    (async_in[gi]),
         .o_q    (sync_out[gi])
      );
   end

   assign lock_s  = sync_out[0];
   assign dmi_s   = sync_out[1];
   assign calib_s = sync_out[2];

   state_e      state_q, state_d;
   logic [15:0] cnt_q, cnt_d;
   logic        timeout_q, timeout_d;
   logic        dbg_q, ddr_q, sys_q;
   logic        cnt_zero;
   logic        lock_guarded;

   assign cnt_zero = (cnt_q == 16'd0);

   // States in which a drop of lock restarts the sequence.
   assign lock_guarded = (state_q == ST_DBG_REL) || (state_q == ST_DDR_REL) ||
                         (state_q == ST_WAIT_CALIB) || (state_q == ST_RUN) ||
                         (state_q == ST_DM_RST);

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      timeout_d = timeout_q;

      case (state_q)
         ST_IDLE: begin
            state_d = ST_WAIT_LOCK;
            cnt_d   = LOCK_WAIT - 16'd1;
         end
         ST_WAIT_LOCK: begin
            if (!lock_s) begin
               // Any unlocked cycle restarts the stability window.
               cnt_d = LOCK_WAIT - 16'd1;
            end else if (cnt_zero) begin
               state_d = ST_DBG_REL;
               cnt_d   = DDR_DELAY - 16'd1;
            end else begin
               cnt_d = cnt_q - 16'd1;
            end
         end
         ST_DBG_REL: begin
            if (cnt_zero) begin
               state_d = ST_DDR_REL;
            end else begin
               cnt_d = cnt_q - 16'd1;
            end
         end
         ST_DDR_REL: begin
            state_d = ST_WAIT_CALIB;
            cnt_d   = CALIB_TIMEOUT;
         end
         ST_WAIT_CALIB: begin
            if (calib_s) begin
               state_d = ST_RUN;
            end else if (cnt_zero) begin
               state_d   = ST_RUN;
               timeout_d = 1'b1;
            end else begin
               cnt_d = cnt_q - 16'd1;
            end
         end
         ST_RUN: begin
            if (dmi_s) begin
               state_d = ST_DM_RST;
               cnt_d   = DMI_HOLD - 16'd1;
            end
         end
         ST_DM_RST: begin
            // Minimum hold runs out first; a still-active request extends it.
            if (!cnt_zero) begin
               cnt_d = cnt_q - 16'd1;
            end else if (!dmi_s) begin
               state_d = ST_RUN;
            end
         end
         default: begin
            state_d = ST_IDLE;
            cnt_d   = 16'd0;
         end
      endcase

      // Lock loss overrides every other transition.
      if (lock_guarded && !lock_s) begin
         state_d = ST_WAIT_LOCK;
         cnt_d   = LOCK_WAIT - 16'd1;
      end
   end

   // Reset outputs are decoded from the next state so that each flop changes
   // on the same edge as the state it belongs to.
   always_ff @(posedge i_clk or negedge i_nrst) begin
      if (!i_nrst) begin
         state_q   <= ST_IDLE;
         cnt_q     <= 16'd0;
         timeout_q <= 1'b0;
         dbg_q     <= 1'b0;
         ddr_q     <= 1'b0;
         sys_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         timeout_q <= timeout_d;
         dbg_q     <= st_dbg_up(state_d);
         ddr_q     <= st_ddr_up(state_d);
         sys_q     <= st_sys_up(state_d);
      end
   end

   assign o_dbg_nrst      = dbg_q;
   assign o_ddr_nrst      = ddr_q;
   assign o_sys_nrst      = sys_q;
   assign o_state         = state_q;
   assign o_calib_timeout = timeout_q;

endmodule
